uart_frame_parser: RTL
======================

// Module: uart_frame_parser
// PURPOSE
//  Byte-level frame parser downstream of the 16x-oversampling UART receiver. Consumes rx byte + rdsig level,
//  hunts header 0xAA, captures CMD, LEN, payload into local buffer, checks checksum, presents frame to host logic.
//  Holds completed frame until acknowledged; aborts partial frames on bad length or inter-byte timeout.
// PARAMETERS
//  MAX_LEN      16    max payload bytes; buffer depth; power of 2, 2..256
//  LW           5     width of frame_len; must hold MAX_LEN (clog2(MAX_LEN+1))
//  TIMEOUT_CYC  2048  clk cycles allowed between byte strobes inside a frame (1 byte = 160 clk)
// PORTS
//  clk          in   1   sampling clock (same 16x-baud clock as receiver)
//  rst_n        in   1   synchronous reset, active-low
//  rx_data      in   8   received byte; stable when rx_sig rises
//  rx_sig       in   1   receiver ready level; held high several cycles per byte
//  frame_ack    in   1   host consumed frame; honoured only while frame_rdy=1
//  rd_addr      in   clog2(MAX_LEN)  payload buffer read address
//  rd_data      out  8   payload byte at rd_addr, registered (1-cycle read latency)
//  frame_rdy    out  1   valid frame held; level until frame_ack
//  frame_cmd    out  8   CMD byte of held frame
//  frame_len    out  LW  payload length of held frame
//  err_len      out  1   1-cycle pulse: LEN > MAX_LEN
//  err_timeout  out  1   1-cycle pulse: inter-byte timeout mid-frame
//  err_csum     out  1   1-cycle pulse: checksum mismatch
//  drop_cnt     out  8   bytes discarded while frame_rdy=1; saturates at 255
// BEHAVIOUR
//  - Clock clk, reset rst_n: one clock; reset is synchronous, active-low. All outputs 0 on reset; state HUNT.
//  - Byte strobe stb = rx_sig & ~rx_sig_q (rising edge; rx_sig_q resets to 0). rx_data sampled at stb cycle.
//  - FSM: HUNT -> CMD -> LEN -> DATA -> CSUM -> HOLD -> HUNT.
//    HUNT: stb with 0xAA -> CMD; other bytes ignored silently (not counted).
//    CMD: stb -> latch cmd, sum=cmd -> LEN.
//    LEN: stb; byte>MAX_LEN -> err_len, HUNT; byte==0 -> CSUM; else -> DATA, idx=0. sum+=byte.
//    DATA: stb -> buf[idx]=byte, sum+=byte, idx++; after idx==len-1 -> CSUM.
//    CSUM: stb; byte==sum -> HOLD; else err_csum, HUNT.
//    HOLD: frame_rdy=1; frame_cmd/frame_len stable; stb -> drop_cnt+1 (sat); frame_ack -> HUNT next cycle.
//  - sum is 8-bit, mod 256 (carry discarded).
//  - frame_rdy rises cycle after checksum stb; falls cycle after frame_ack.
//  - stb and frame_ack same cycle in HOLD: byte dropped (counted), exit to HUNT; byte not treated as header.
//  - Timeout: counter clears on every stb; in CMD/LEN/DATA/CSUM reaching TIMEOUT_CYC -> err_timeout, HUNT.
//    Counter idle in HUNT/HOLD. Same-cycle stb and timeout: stb wins.
//  - Errors are mutually exclusive 1-cycle pulses; buffer contents after error are don't-care.
//  - Buffer write only in DATA; rd_data valid for rd_addr<frame_len while frame_rdy; else don't-care.
//  - frame_ack outside HOLD ignored. drop_cnt cleared only by reset.
//  - Reset mid-frame: partial frame discarded, HUNT, no error pulse.
// CONFIGURATION
//  - UART_FRAME_CSUM_EN defined: CSUM state present, checksum checked as above.
//  - Not defined: no CSUM state; last payload byte (or LEN==0) -> HOLD directly; err_csum tied 0.
// STRUCTURE
//  - Shared include uart_frame_pkg: FSM state encodings, FRAME_HDR=8'hAA, default MAX_LEN/TIMEOUT_CYC.
//  - Sub-module uart_frame_buf: MAX_LEN x 8 single-write, single-registered-read buffer.
//  - Top holds edge detect, FSM, checksum, timeout counter, drop counter.
// TESTING
//  - AA 05 02 11 22 CS=0x3A -> frame_rdy=1, cmd=05, len=2, buf[0]=11, buf[1]=22; ack -> rdy=0 next cycle.
//  - AA 05 02 11 22 3B -> err_csum pulse, frame_rdy stays 0; next good frame accepted.
//  - AA 01 11 (MAX_LEN=16) -> err_len pulse; following AA 01 00 01 -> frame_rdy, len=0.
//  - AA 05 then silence 2048 clk -> err_timeout once; later full frame accepted.
//  - Frame held, send 3 bytes incl. one on ack cycle -> drop_cnt=3, state HUNT, no spurious frame.
//  - rx_sig held high 33 cycles per byte -> exactly one stb per byte; rst_n=0 during DATA -> outputs 0, HUNT.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser.
// The StCsum state exists only when UART_FRAME_CSUM_EN is defined.
package uart_frame_pkg;

  localparam logic [7:0]  FRAME_HDR       = 8'hAA;
  localparam int unsigned DEF_MAX_LEN     = 16;
  localparam int unsigned DEF_TIMEOUT_CYC = 2048;

  typedef enum logic [2:0] {
    StHunt,
    StCmd,
    StLen,
    StData,
`ifdef UART_FRAME_CSUM_EN
    StCsum,
`endif
    StHold
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: one write port, one read port with a registered output.
module uart_frame_buf #(
  parameter int unsigned Depth = 16,
  parameter int unsigned AW    = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem_q [Depth];
  logic [7:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_data_q <= 8'h00;
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/uart_frame_parser.sv
// Frame parser behind the UART receiver: hunts 0xAA, captures CMD/LEN/payload, holds until ack.
// Define UART_FRAME_CSUM_EN to add the trailing checksum byte and err_csum reporting.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int unsigned MAX_LEN     = DEF_MAX_LEN,
  parameter int unsigned LW          = $clog2(MAX_LEN + 1),
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int unsigned AW         = $clog2(MAX_LEN)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [7:0]    rx_data_i,
  input  logic          rx_sig_i,
  input  logic          frame_ack_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o,
  output logic          frame_rdy_o,
  output logic [7:0]    frame_cmd_o,
  output logic [LW-1:0] frame_len_o,
  output logic          err_len_o,
  output logic          err_timeout_o,
  output logic          err_csum_o,
  output logic [7:0]    drop_cnt_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  state_e        state_q;
  logic          rx_sig_q;
  logic          rdy_q;
  logic          err_len_q;
  logic          err_tmo_q;
  logic [7:0]    cmd_q;
  logic [7:0]    drop_q;
  logic [LW-1:0] len_q;
  logic [AW-1:0] idx_q;
  logic [TW-1:0] tmo_q, tmo_d;
`ifdef UART_FRAME_CSUM_EN
  logic [7:0]    sum_q;
  logic          err_csum_q;
`endif

  logic stb, in_frame, tmo_hit, last_byte, len_bad, wr_en;

  always_comb begin
    stb       = rx_sig_i & ~rx_sig_q;
    in_frame  = (state_q != StHunt) && (state_q != StHold);
    // A strobe on the expiry cycle keeps the frame alive.
    tmo_hit   = in_frame && !stb && (tmo_q == TW'(TIMEOUT_CYC - 1));
    tmo_d     = (in_frame && !stb && !tmo_hit) ? tmo_q + TW'(1) : '0;
    last_byte = (LW'(idx_q) == len_q - LW'(1));
    len_bad   = ({1'b0, rx_data_i} > 9'(MAX_LEN));
    wr_en     = (state_q == StData) && stb;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StHunt;
      rx_sig_q   <= 1'b0;
      rdy_q      <= 1'b0;
      err_len_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
      cmd_q      <= 8'h00;
      drop_q     <= 8'h00;
      len_q      <= '0;
      idx_q      <= '0;
      tmo_q      <= '0;
`ifdef UART_FRAME_CSUM_EN
      sum_q      <= 8'h00;
      err_csum_q <= 1'b0;
`endif
    end else begin
      rx_sig_q   <= rx_sig_i;
      tmo_q      <= tmo_d;
      err_len_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
`ifdef UART_FRAME_CSUM_EN
      err_csum_q <= 1'b0;
`endif
      if (tmo_hit) begin
        err_tmo_q <= 1'b1;
        state_q   <= StHunt;
      end else begin
        unique case (state_q)
          StHunt: begin
            if (stb && rx_data_i == FRAME_HDR) state_q <= StCmd;
          end
          StCmd: begin
            if (stb) begin
              cmd_q   <= rx_data_i;
`ifdef UART_FRAME_CSUM_EN
              sum_q   <= rx_data_i;
`endif
              state_q <= StLen;
            end
          end
          StLen: begin
            if (stb) begin
              if (len_bad) begin
                err_len_q <= 1'b1;
                state_q   <= StHunt;
              end else begin
                len_q <= LW'(rx_data_i);
                idx_q <= '0;
`ifdef UART_FRAME_CSUM_EN
                sum_q <= sum_q + rx_data_i;
                state_q <= (rx_data_i == 8'h00) ? StCsum : StData;
`else
                if (rx_data_i == 8'h00) begin
                  state_q <= StHold;
                  rdy_q   <= 1'b1;
                end else begin
                  state_q <= StData;
                end
`endif
              end
            end
          end
          StData: begin
            if (stb) begin
              idx_q <= idx_q + AW'(1);
`ifdef UART_FRAME_CSUM_EN
              sum_q <= sum_q + rx_data_i;
              if (last_byte) state_q <= StCsum;
`else
              if (last_byte) begin
                state_q <= StHold;
                rdy_q   <= 1'b1;
              end
`endif
            end
          end
`ifdef UART_FRAME_CSUM_EN
          StCsum: begin
            if (stb) begin
              if (rx_data_i == sum_q) begin
                state_q <= StHold;
                rdy_q   <= 1'b1;
              end else begin
                err_csum_q <= 1'b1;
                state_q    <= StHunt;
              end
            end
          end
`endif
          StHold: begin
            // A byte arriving with the ack is still dropped, never taken as a header.
            if (stb) drop_q <= sat_inc8(drop_q);
            if (frame_ack_i) begin
              state_q <= StHunt;
              rdy_q   <= 1'b0;
            end
          end
          default: state_q <= StHunt;
        endcase
      end
    end
  end

  uart_frame_buf #(
    .Depth (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (wr_en),
    .wr_addr_i (idx_q),
    .wr_data_i (rx_data_i),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o)
  );

  assign frame_rdy_o   = rdy_q;
  assign frame_cmd_o   = cmd_q;
  assign frame_len_o   = len_q;
  assign err_len_o     = err_len_q;
  assign err_timeout_o = err_tmo_q;
  assign drop_cnt_o    = drop_q;
`ifdef UART_FRAME_CSUM_EN
  assign err_csum_o    = err_csum_q;
`else
  assign err_csum_o    = 1'b0;
`endif

endmodule
